mmu_pt_loader: RTL and testbench

//  Sequences context-switch reloads of the MMU page table. On request, fetches 16

---
 rtl/mmu_pt_loader_pkg.sv | 23 ++
 rtl/mmu_pt_loader.sv | 141 ++++++++++++++
 tb/tb_mmu_pt_loader.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/mmu_pt_loader_pkg.sv
// Shared sizing, state encoding and SR index helper for the MMU page-table loader.
package mmu_pt_loader_pkg;

  localparam int unsigned RW         = 16;
  localparam int unsigned EXT_ADDR_W = 24;
  localparam int unsigned PT_ENT     = 16;
  localparam int unsigned IDX_W      = $clog2(PT_ENT);

  localparam logic [RW-1:0] SR_START = 16'h0010;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StWr,
    StDone
  } state_e;

  // SR index that holds page-table entry idx.
  function automatic logic [RW-1:0] pt_sel(input logic [IDX_W-1:0] idx);
    return SR_START + RW'(idx);
  endfunction

endpackage

// File: rtl/mmu_pt_loader.sv
// Reloads the MMU page table from external memory on a context switch and
// replays any CPU SR write that arrived while the reload was in flight.
module mmu_pt_loader
  import mmu_pt_loader_pkg::*;
(
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_sw_req,
  input  logic [EXT_ADDR_W-1:0] i_sw_base,
  input  logic                  i_sw_paging,
  output logic                  o_mem_req,
  output logic [EXT_ADDR_W-1:0] o_mem_addr,
  input  logic                  i_mem_ack,
  input  logic [RW-1:0]         i_mem_data,
  input  logic [RW-1:0]         i_cpu_sr_sel,
  input  logic [RW-1:0]         i_cpu_sr_data,
  input  logic                  i_cpu_sr_ie,
  input  logic                  i_cpu_pg_we,
  input  logic                  i_cpu_pg_val,
  output logic [RW-1:0]         o_sr_pt_sel,
  output logic [RW-1:0]         o_sr_data,
  output logic                  o_sr_pt_ie,
  output logic                  o_paging_enable,
  output logic                  o_busy,
  output logic                  o_done
);

  state_e                state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [EXT_ADDR_W-1:0] base_q, base_d;
  logic                  pg_lat_q, pg_lat_d;
  logic [RW-1:0]         word_q, word_d;
  logic                  paging_q, paging_d;
  logic                  busy_q;
  logic                  hold_vld_q, hold_vld_d;
  logic [RW-1:0]         hold_sel_q, hold_sel_d;
  logic [RW-1:0]         hold_data_q, hold_data_d;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    base_d      = base_q;
    pg_lat_d    = pg_lat_q;
    word_d      = word_q;
    paging_d    = paging_q;
    hold_vld_d  = hold_vld_q;
    hold_sel_d  = hold_sel_q;
    hold_data_d = hold_data_q;
    o_mem_req   = 1'b0;
    o_sr_pt_ie  = 1'b0;
    o_sr_pt_sel = '0;
    o_sr_data   = '0;

    unique case (state_q)
      StIdle: begin
        o_sr_pt_ie  = i_cpu_sr_ie;
        o_sr_pt_sel = i_cpu_sr_sel;
        o_sr_data   = i_cpu_sr_data;
        if (i_cpu_pg_we) paging_d = i_cpu_pg_val;
        if (i_sw_req) begin
          base_d   = i_sw_base;
          idx_d    = '0;
          pg_lat_d = i_sw_paging;
          state_d  = StReq;
        end
      end
      StReq: begin
        o_mem_req = 1'b1;
        if (i_mem_ack) begin
          word_d  = i_mem_data;
          state_d = StWr;
        end
      end
      StWr: begin
        o_sr_pt_ie  = 1'b1;
        o_sr_pt_sel = pt_sel(idx_q);
        o_sr_data   = word_q;
        if (idx_q == IDX_W'(PT_ENT - 1)) begin
          state_d = StDone;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = StReq;
        end
      end
      StDone: begin
        paging_d   = pg_lat_q;
        hold_vld_d = 1'b0;
        // A CPU write landing in this very cycle is newer than the held one.
        if (i_cpu_sr_ie) begin
          o_sr_pt_ie  = 1'b1;
          o_sr_pt_sel = i_cpu_sr_sel;
          o_sr_data   = i_cpu_sr_data;
        end else if (hold_vld_q) begin
          o_sr_pt_ie  = 1'b1;
          o_sr_pt_sel = hold_sel_q;
          o_sr_data   = hold_data_q;
        end
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if ((state_q == StReq || state_q == StWr) && i_cpu_sr_ie) begin
      hold_vld_d  = 1'b1;
      hold_sel_d  = i_cpu_sr_sel;
      hold_data_d = i_cpu_sr_data;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      base_q      <= '0;
      pg_lat_q    <= 1'b0;
      word_q      <= '0;
      paging_q    <= 1'b0;
      busy_q      <= 1'b0;
      hold_vld_q  <= 1'b0;
      hold_sel_q  <= '0;
      hold_data_q <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      base_q      <= base_d;
      pg_lat_q    <= pg_lat_d;
      word_q      <= word_d;
      paging_q    <= paging_d;
      busy_q      <= (state_d != StIdle);
      hold_vld_q  <= hold_vld_d;
      hold_sel_q  <= hold_sel_d;
      hold_data_q <= hold_data_d;
    end
  end

  assign o_mem_addr      = base_q + EXT_ADDR_W'(idx_q);
  assign o_paging_enable = paging_q;
  assign o_busy          = busy_q;
  assign o_done          = (state_q == StDone);

endmodule

// File: tb/tb_mmu_pt_loader.sv
// Directed bench for mmu_pt_loader: a small memory responder with optional ack
// delay, a log of MMU SR writes, and hand-derived expectations per load.
module tb_mmu_pt_loader;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_sw_req;
  logic [23:0] i_sw_base;
  logic        i_sw_paging;
  logic        o_mem_req;
  logic [23:0] o_mem_addr;
  logic        i_mem_ack;
  logic [15:0] i_mem_data;
  logic [15:0] i_cpu_sr_sel;
  logic [15:0] i_cpu_sr_data;
  logic        i_cpu_sr_ie;
  logic        i_cpu_pg_we;
  logic        i_cpu_pg_val;
  logic [15:0] o_sr_pt_sel;
  logic [15:0] o_sr_data;
  logic        o_sr_pt_ie;
  logic        o_paging_enable;
  logic        o_busy;
  logic        o_done;

  mmu_pt_loader dut (
    .i_clk           (i_clk),
    .i_rst           (i_rst),
    .i_sw_req        (i_sw_req),
    .i_sw_base       (i_sw_base),
    .i_sw_paging     (i_sw_paging),
    .o_mem_req       (o_mem_req),
    .o_mem_addr      (o_mem_addr),
    .i_mem_ack       (i_mem_ack),
    .i_mem_data      (i_mem_data),
    .i_cpu_sr_sel    (i_cpu_sr_sel),
    .i_cpu_sr_data   (i_cpu_sr_data),
    .i_cpu_sr_ie     (i_cpu_sr_ie),
    .i_cpu_pg_we     (i_cpu_pg_we),
    .i_cpu_pg_val    (i_cpu_pg_val),
    .o_sr_pt_sel     (o_sr_pt_sel),
    .o_sr_data       (o_sr_data),
    .o_sr_pt_ie      (o_sr_pt_ie),
    .o_paging_enable (o_paging_enable),
    .o_busy          (o_busy),
    .o_done          (o_done)
  );

  always #5 i_clk = ~i_clk;

  int          n_vec = 0;
  int          n_err = 0;
  logic [15:0] wsel [0:31];
  logic [15:0] wdat [0:31];
  int          wr_n;
  int          done_busy;
  bit          done_seen;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Runs one load; memory word k holds 16'h0100+k, ack after 0..maxdly cycles.
  task automatic do_load(input logic [23:0] base, input int maxdly, input bit hold,
                         input bit cpu_wr);
    int          k;
    int          wait_left;
    int          busy_cnt;
    bit          pend;
    logic [23:0] ea;
    wr_n      = 0;
    k         = 0;
    busy_cnt  = 0;
    pend      = 1'b0;
    done_seen = 1'b0;
    done_busy = 0;
    wait_left = $urandom_range(maxdly, 0);
    @(negedge i_clk);
    i_sw_req    = 1'b1;
    i_sw_base   = base;
    i_sw_paging = 1'b1;
    for (int cyc = 0; cyc < 600 && !done_seen; cyc++) begin
      @(negedge i_clk);
      if (!hold) i_sw_req = 1'b0;
      i_mem_ack   = 1'b0;
      i_mem_data  = 16'hDEAD;
      i_cpu_sr_ie = 1'b0;
      i_cpu_pg_we = 1'b0;
      if (o_busy) busy_cnt++;
      if (o_sr_pt_ie && wr_n < 32) begin
        wsel[wr_n] = o_sr_pt_sel;
        wdat[wr_n] = o_sr_data;
        wr_n++;
      end
      if (pend) chk("req_held", {31'd0, o_mem_req}, 32'd1);
      if (o_mem_req) begin
        ea = base + 24'(k);
        chk("mem_addr", {8'd0, o_mem_addr}, {8'd0, ea});
        chk("ie_in_req", {31'd0, o_sr_pt_ie}, 32'd0);
        if (wait_left == 0) begin
          i_mem_ack  = 1'b1;
          i_mem_data = 16'h0100 + 16'(k);
          k++;
          wait_left  = $urandom_range(maxdly, 0);
          pend       = 1'b0;
        end else begin
          wait_left--;
          pend = 1'b1;
        end
      end
      if (o_done) begin
        done_seen = 1'b1;
        done_busy = busy_cnt;
      end
      if (cpu_wr) begin
        if (busy_cnt == 8) chk("pg_we_ignored", {31'd0, o_paging_enable}, 32'd1);
        if (busy_cnt == 5) begin
          i_cpu_sr_ie = 1'b1; i_cpu_sr_sel = 16'h0013; i_cpu_sr_data = 16'h0ABC;
        end
        if (busy_cnt == 7) begin
          i_cpu_pg_we = 1'b1; i_cpu_pg_val = 1'b0;
        end
        if (busy_cnt == 10) begin
          i_cpu_sr_ie = 1'b1; i_cpu_sr_sel = 16'h0014; i_cpu_sr_data = 16'h0DEF;
        end
      end
    end
    chk("done_seen", {31'd0, done_seen}, 32'd1);
  endtask

  task automatic check_table(input int n_exp);
    chk("write_count", wr_n, n_exp);
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("sel[%0d]", k), {16'd0, wsel[k]}, 32'h10 + k);
      chk($sformatf("data[%0d]", k), {16'd0, wdat[k]}, 32'h0100 + k);
    end
  endtask

  initial begin
    i_rst = 1'b1; i_sw_req = 1'b0; i_sw_base = '0; i_sw_paging = 1'b0;
    i_mem_ack = 1'b0; i_mem_data = '0; i_cpu_sr_sel = '0; i_cpu_sr_data = '0;
    i_cpu_sr_ie = 1'b0; i_cpu_pg_we = 1'b0; i_cpu_pg_val = 1'b0;
    repeat (2) @(negedge i_clk);
    chk("rst_busy", {31'd0, o_busy}, 32'd0);
    chk("rst_req", {31'd0, o_mem_req}, 32'd0);
    chk("rst_addr", {8'd0, o_mem_addr}, 32'd0);
    chk("rst_pg", {31'd0, o_paging_enable}, 32'd0);
    chk("rst_done", {31'd0, o_done}, 32'd0);
    i_rst = 1'b0;

    // Idle pass-through and CPU paging write
    @(negedge i_clk);
    i_cpu_sr_ie = 1'b1; i_cpu_sr_sel = 16'h0022; i_cpu_sr_data = 16'h1234;
    i_cpu_pg_we = 1'b1; i_cpu_pg_val = 1'b1;
    #1;
    chk("pass_ie", {31'd0, o_sr_pt_ie}, 32'd1);
    chk("pass_sel", {16'd0, o_sr_pt_sel}, 32'h0022);
    chk("pass_data", {16'd0, o_sr_data}, 32'h1234);
    @(negedge i_clk);
    i_cpu_sr_ie = 1'b0; i_cpu_pg_we = 1'b0;
    chk("cpu_pg", {31'd0, o_paging_enable}, 32'd1);

    // Reset asserted mid-REQ
    i_sw_req = 1'b1; i_sw_base = 24'h00ABCD; i_sw_paging = 1'b1;
    @(negedge i_clk);
    i_sw_req = 1'b0;
    chk("t1_req", {31'd0, o_mem_req}, 32'd1);
    chk("t1_addr", {8'd0, o_mem_addr}, 32'h00ABCD);
    #2 i_rst = 1'b1;
    #1;
    chk("t1_req_rst", {31'd0, o_mem_req}, 32'd0);
    chk("t1_busy_rst", {31'd0, o_busy}, 32'd0);
    chk("t1_addr_rst", {8'd0, o_mem_addr}, 32'd0);
    chk("t1_pg_rst", {31'd0, o_paging_enable}, 32'd0);
    chk("t1_ie_rst", {31'd0, o_sr_pt_ie}, 32'd0);
    @(negedge i_clk);
    i_rst = 1'b0;

    // Zero-wait load
    do_load(24'h001000, 0, 1'b0, 1'b0);
    chk("t2_done_cycle", done_busy, 33);
    check_table(16);
    chk("t2_pg", {31'd0, o_paging_enable}, 32'd0);
    @(negedge i_clk);
    chk("t2_pg_after", {31'd0, o_paging_enable}, 32'd1);
    chk("t2_busy_after", {31'd0, o_busy}, 32'd0);

    // Random ack delays
    do_load(24'h123450, 5, 1'b0, 1'b0);
    check_table(16);

    // Address wrap
    do_load(24'hFFFFF8, 2, 1'b0, 1'b0);
    check_table(16);

    // CPU writes held during load; last one replayed in the done cycle
    do_load(24'h000200, 0, 1'b0, 1'b1);
    check_table(17);
    chk("t5_replay_sel", {16'd0, wsel[16]}, 32'h0014);
    chk("t5_replay_data", {16'd0, wdat[16]}, 32'h0DEF);
    @(negedge i_clk);
    chk("t5_pg", {31'd0, o_paging_enable}, 32'd1);

    // Request held high: one load, next starts right after one idle cycle
    do_load(24'h000400, 0, 1'b1, 1'b0);
    check_table(16);
    @(negedge i_clk);
    chk("t6_idle_busy", {31'd0, o_busy}, 32'd0);
    chk("t6_idle_req", {31'd0, o_mem_req}, 32'd0);
    @(negedge i_clk);
    i_sw_req = 1'b0;
    chk("t6_restart_busy", {31'd0, o_busy}, 32'd1);
    chk("t6_restart_req", {31'd0, o_mem_req}, 32'd1);
    chk("t6_restart_addr", {8'd0, o_mem_addr}, 32'h000400);
    i_rst = 1'b1;
    @(negedge i_clk);
    i_rst = 1'b0;
    @(negedge i_clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
